// File: rtl/peridot_pfc_bridge.sv
// Avalon-MM slave that converts CPU register accesses into PERIDOT PFC command-bus cycles.
// Byte-enable writes become a read-modify-write because the PFC banks accept only full words.
module peridot_pfc_bridge #(
    parameter int NUM_BANKS    = 4,
    parameter int RESP_LATENCY = 1
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        coe_pfc_clk,
    output logic        coe_pfc_reset,
    output logic [36:0] coe_pfc_cmd,
    input  logic [31:0] coe_pfc_resp
);

    typedef enum logic [1:0] {IDLE, RWAIT, WSTB, ACK} state_t;

    localparam logic [2:0] NB = 3'(NUM_BANKS);
    localparam logic [1:0] RL = 2'(RESP_LATENCY);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] readdata_q, readdata_d;
    logic        wait_q, wait_d;
    logic [36:0] cmd_q, cmd_d;

    logic [31:0] resp_sel;
    logic [31:0] merged;

    function automatic logic bank_ok(input logic [3:0] a);
        return {1'b0, a[3:2]} < NB;
    endfunction

    // Unpopulated banks read as zero regardless of what the decoder returns.
    assign resp_sel = bank_ok(addr_q) ? coe_pfc_resp : 32'h0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged[gi*8 +: 8] = be_q[gi] ? wdata_q[gi*8 +: 8] : resp_sel[gi*8 +: 8];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        is_wr_d    = is_wr_q;
        readdata_d = readdata_q;
        wait_d     = 1'b1;
        cmd_d      = {1'b0, addr_q, 32'h0};
        case (state_q)
            IDLE: begin
                if (avs_write || avs_read) begin
                    addr_d          = avs_address;
                    wdata_d         = avs_writedata;
                    be_d            = avs_byteenable;
                    is_wr_d         = avs_write;
                    cmd_d[35:32]    = avs_address;
                    if (avs_write && avs_byteenable == 4'hF) begin
                        state_d = WSTB;
                        cmd_d   = {bank_ok(avs_address), avs_address, avs_writedata};
                    end else if (avs_write && avs_byteenable == 4'h0) begin
                        state_d = ACK;
                        wait_d  = 1'b0;
                    end else begin
                        state_d = RWAIT;
                        cnt_d   = RL;
                    end
                end
            end
            RWAIT: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else if (is_wr_q) begin
                    // The merge reads the settled response directly, so no separate buffer is kept.
                    state_d = WSTB;
                    cmd_d   = {bank_ok(addr_q), addr_q, merged};
                end else begin
                    state_d    = ACK;
                    wait_d     = 1'b0;
                    readdata_d = resp_sel;
                end
            end
            WSTB: begin
                state_d = ACK;
                wait_d  = 1'b0;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            addr_q     <= 4'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            is_wr_q    <= 1'b0;
            readdata_q <= 32'h0;
            wait_q     <= 1'b1;
            cmd_q      <= 37'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            is_wr_q    <= is_wr_d;
            readdata_q <= readdata_d;
            wait_q     <= wait_d;
            cmd_q      <= cmd_d;
        end
    end

    assign avs_readdata    = readdata_q;
    assign avs_waitrequest = wait_q;
    assign coe_pfc_cmd     = cmd_q;
    assign coe_pfc_clk     = csi_clk;
    assign coe_pfc_reset   = rsi_reset;

endmodule

// File: tb/tb_peridot_pfc_bridge.sv
// Directed bench: three bridge instances (latency 1, latency 3, three banks with latency 0)
// each driven by its own Avalon master and PFC bank model.
module tb_peridot_pfc_bridge;

    localparam int RL_T [3] = '{1, 3, 0};
    localparam int NB_T [3] = '{4, 4, 3};

    logic        clk = 1'b0;
    logic        rst      [3];
    logic        rd       [3];
    logic        wr       [3];
    logic [3:0]  addr     [3];
    logic [31:0] wdat     [3];
    logic [3:0]  be       [3];
    logic [31:0] rdata_s  [3];
    logic        wait_s   [3];
    logic [36:0] cmd_s    [3];
    int          stb_cnt  [3];
    logic [31:0] stb_val  [3];
    logic [31:0] mem      [3][16];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [31:0] resp_l;
        logic [31:0] rdata_l;
        logic        wait_l;
        logic [36:0] cmd_l;
        logic        pclk_l;
        logic        prst_l;
        logic [3:0]  prev_l   = 4'h0;
        int          settle_l = 8;
        int          eff_l;
        int          cnt_l    = 0;
        logic [31:0] val_l    = 32'h0;

        peridot_pfc_bridge #(.NUM_BANKS(NB_T[gi]), .RESP_LATENCY(RL_T[gi])) dut (
            .csi_clk         (clk),
            .rsi_reset       (rst[gi]),
            .avs_address     (addr[gi]),
            .avs_read        (rd[gi]),
            .avs_write       (wr[gi]),
            .avs_writedata   (wdat[gi]),
            .avs_byteenable  (be[gi]),
            .avs_readdata    (rdata_l),
            .avs_waitrequest (wait_l),
            .coe_pfc_clk     (pclk_l),
            .coe_pfc_reset   (prst_l),
            .coe_pfc_cmd     (cmd_l),
            .coe_pfc_resp    (resp_l)
        );

        // Bank model: response is garbage until the address has been stable for RESP_LATENCY cycles.
        always @(posedge clk) begin
            prev_l <= cmd_l[35:32];
            if (cmd_l[35:32] != prev_l) settle_l <= 1;
            else if (settle_l < 8) settle_l <= settle_l + 1;
            if (cmd_l[36]) begin
                cnt_l <= cnt_l + 1;
                val_l <= cmd_l[31:0];
            end
        end

        always_comb begin
            eff_l  = (cmd_l[35:32] != prev_l) ? 0 : settle_l;
            resp_l = (eff_l >= RL_T[gi]) ? mem[gi][cmd_l[35:32]] : 32'hBAD0BAD0;
        end

        assign rdata_s[gi] = rdata_l;
        assign wait_s[gi]  = wait_l;
        assign cmd_s[gi]   = cmd_l;
        assign stb_cnt[gi] = cnt_l;
        assign stb_val[gi] = val_l;
    end

    typedef struct {
        int          d;
        logic        w;
        logic        r;
        logic [3:0]  a;
        logic [31:0] dat;
        logic [3:0]  b;
        int          exp_ack;
        int          exp_stb;
        logic [31:0] exp_val;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic r, input logic [3:0] a,
                        input logic [31:0] dat, input logic [3:0] b,
                        output int ack, output logic [36:0] c1, output logic [31:0] rdo);
        @(negedge clk);
        wr[d] = w; rd[d] = r; addr[d] = a; wdat[d] = dat; be[d] = b;
        ack = -1; c1 = '0; rdo = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) c1 = cmd_s[d];
            if (!wait_s[d]) begin
                ack = n;
                rdo = rdata_s[d];
                break;
            end
        end
        if (ack < 0) chk("ack_timeout", 64'(ack), 64'd0);
        @(negedge clk);
        wr[d] = 1'b0; rd[d] = 1'b0;
    endtask

    initial begin
        int          ack, s0;
        logic [36:0] c1;
        logic [31:0] rdo;

        vecs[0]  = '{0, 1'b0, 1'b1, 4'hD, 32'h0,        4'h0, 3, 0, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1, 1'b0, 1'b1, 4'hD, 32'h0,        4'h0, 5, 0, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 1'b0, 4'h5, 32'hAABBCCDD, 4'h5, 4, 1, 32'h11BB33DD, 32'hDEADBEEF};
        vecs[3]  = '{1, 1'b1, 1'b0, 4'h5, 32'hAABBCCDD, 4'h5, 6, 1, 32'h11BB33DD, 32'hDEADBEEF};
        vecs[4]  = '{0, 1'b1, 1'b0, 4'h5, 32'h12345678, 4'h0, 1, 0, 32'h0,        32'hDEADBEEF};
        vecs[5]  = '{0, 1'b1, 1'b1, 4'h6, 32'h00000055, 4'hF, 2, 1, 32'h00000055, 32'hDEADBEEF};
        vecs[6]  = '{2, 1'b0, 1'b1, 4'hD, 32'h0,        4'h0, 2, 0, 32'h0,        32'h0};
        vecs[7]  = '{2, 1'b1, 1'b0, 4'hC, 32'hFFFFFFFF, 4'hF, 2, 0, 32'h0,        32'h0};
        vecs[8]  = '{2, 1'b0, 1'b1, 4'h9, 32'h0,        4'h0, 2, 0, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{2, 1'b1, 1'b0, 4'h9, 32'hAA000000, 4'h8, 3, 1, 32'hAAFEF00D, 32'hCAFEF00D};
        vecs[10] = '{0, 1'b0, 1'b1, 4'h5, 32'h0,        4'h0, 3, 0, 32'h0,        32'h11223344};

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
            mem[d][4'hD] = 32'hDEADBEEF;
            mem[d][4'h5] = 32'h11223344;
            mem[d][4'h9] = 32'hCAFEF00D;
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = 4'h0; wdat[d] = 32'h0; be[d] = 4'h0;
        end

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_wait", 64'(wait_s[d]), 64'd1);
            chk("reset_cmd", 64'(cmd_s[d]), 64'd0);
            chk("reset_rdata", 64'(rdata_s[d]), 64'd0);
            $display("reset dut%0d: wait=%0d cmd=%0h rdata=%0h", d, wait_s[d], cmd_s[d], rdata_s[d]);
        end

        // Full write: strobe with the whole command visible at T1, ack at T2.
        s0 = stb_cnt[0];
        xfer(0, 1'b1, 1'b0, 4'b0110, 32'h00110000, 4'hF, ack, c1, rdo);
        chk("full_wr_cmd_t1", 64'(c1), 64'(37'h16_0011_0000));
        chk("full_wr_ack", 64'(ack), 64'd2);
        chk("full_wr_stb_cnt", 64'(stb_cnt[0] - s0), 64'd1);
        $display("full write dut0: ack=T%0d cmd_t1=%0h strobes=%0d", ack, c1, stb_cnt[0] - s0);

        for (int i = 0; i < 11; i++) begin
            int d;
            d  = vecs[i].d;
            s0 = stb_cnt[d];
            xfer(d, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].dat, vecs[i].b, ack, c1, rdo);
            chk($sformatf("v%0d_ack", i), 64'(ack), 64'(vecs[i].exp_ack));
            chk($sformatf("v%0d_stb_cnt", i), 64'(stb_cnt[d] - s0), 64'(vecs[i].exp_stb));
            if (vecs[i].exp_stb == 1)
                chk($sformatf("v%0d_stb_val", i), 64'(stb_val[d]), 64'(vecs[i].exp_val));
            chk($sformatf("v%0d_rdata", i), 64'(rdo), 64'(vecs[i].exp_rd));
            $display("vec %0d dut%0d w=%0d r=%0d a=%0h be=%0h: ack=T%0d strobes=%0d stb=%0h rdata=%0h",
                     i, d, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].b, ack, stb_cnt[d] - s0,
                     stb_val[d], rdo);
        end

        // Reset during RWAIT of a partial write: no strobe, then a normal full write.
        s0 = stb_cnt[1];
        @(negedge clk);
        wr[1] = 1'b1; addr[1] = 4'h5; wdat[1] = 32'hAABBCCDD; be[1] = 4'h5;
        repeat (2) @(negedge clk);
        rst[1] = 1'b1; wr[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        chk("rst_mid_wait", 64'(wait_s[1]), 64'd1);
        chk("rst_mid_strobe", 64'(cmd_s[1][36]), 64'd0);
        repeat (6) @(negedge clk);
        chk("rst_mid_no_stb", 64'(stb_cnt[1] - s0), 64'd0);
        chk("rst_mid_wait_idle", 64'(wait_s[1]), 64'd1);
        $display("reset mid-RMW dut1: wait=%0d strobes=%0d", wait_s[1], stb_cnt[1] - s0);

        s0 = stb_cnt[1];
        xfer(1, 1'b1, 1'b0, 4'h0, 32'h12345678, 4'hF, ack, c1, rdo);
        chk("post_rst_ack", 64'(ack), 64'd2);
        chk("post_rst_stb_cnt", 64'(stb_cnt[1] - s0), 64'd1);
        chk("post_rst_stb_val", 64'(stb_val[1]), 64'h12345678);
        $display("post-reset write dut1: ack=T%0d strobes=%0d stb=%0h", ack, stb_cnt[1] - s0, stb_val[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/peridot_pfc_bridge.md
Name: peridot_pfc_bridge

Overview:
- Avalon-MM slave that turns CPU register accesses into the PERIDOT pin-function-controller command bus.
- Drives pfc_cmd[36:0] and samples pfc_resp[31:0]; the top-level bank decoder muxes resp by cmd[35:34].
- Supports byte-enable writes by doing an internal read-modify-write, because the PFC banks accept only full 32-bit writes.

Parameters:
- NUM_BANKS, 4: number of populated banks (1-4). Accesses to a bank index >= NUM_BANKS read as 0 and drop writes.
- RESP_LATENCY, 1: extra cycles allowed for pfc_resp to settle after the address changes (0-3).

Ports:
- csi_clk  in  1  system clock; the only clock
- rsi_reset  in  1  synchronous, active-high reset
- avs_address  in  4  word address: [3:2] bank, [1:0] register
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  32  write data
- avs_byteenable  in  4  byte lanes to write
- avs_readdata  out  32  read data, valid while avs_waitrequest=0 on a read
- avs_waitrequest  out  1  0 only in the single acknowledge cycle
- coe_pfc_clk  out  1  equal to csi_clk
- coe_pfc_reset  out  1  equal to rsi_reset
- coe_pfc_cmd  out  37  [36] write strobe, [35:34] bank, [33:32] register, [31:0] data
- coe_pfc_resp  in  32  selected bank readdata (combinational from cmd address)

Behaviour:
- Clocking and reset:
  - One clock, csi_clk. Reset rsi_reset is synchronous and active-high.
  - All registers update on the rising edge of csi_clk.
- Reset values: avs_waitrequest=1, avs_readdata=0, coe_pfc_cmd=0, FSM=IDLE, latency counter=0.
- FSM states: IDLE, RWAIT, WSTB, ACK.
- IDLE:
  - On avs_write or avs_read (cycle T0), latch address, writedata and byteenable. The latched address drives cmd[35:32] from T1 and holds until ACK ends.
  - If avs_write and avs_read are both high, write wins.
  - Write with byteenable=4'hF goes to WSTB.
  - Write with byteenable=0 goes to ACK with no strobe.
  - Partial write, or read, loads counter=RESP_LATENCY and goes to RWAIT.
- RWAIT:
  - Decrement the counter each cycle.
  - When counter==0, register coe_pfc_resp into rdbuf. Use 0 if bank >= NUM_BANKS.
  - Then go to ACK for a read, or WSTB for a partial write.
  - RWAIT lasts RESP_LATENCY+1 cycles.
- WSTB:
  - cmd[36]=1 for exactly one cycle.
  - cmd[31:0] = latched writedata for a full write. For a partial write, each byte i comes from writedata where byteenable[i]=1, otherwise from rdbuf.
  - If bank >= NUM_BANKS, cmd[36] is forced to 0.
  - Go to ACK.
- ACK:
  - avs_waitrequest=0 for one cycle.
  - For a read, avs_readdata=rdbuf and holds its value until the next read ACK.
  - Return to IDLE. A new request is accepted no earlier than the following cycle.
- cmd[36] is 0 in every state except WSTB. cmd[31:0] is don't-care outside WSTB and is driven 0.
- Latency, request cycle T0 to waitrequest=0:
  - Full write: ACK at T2.
  - Read: ACK at T2+RESP_LATENCY.
  - Partial write: ACK at T3+RESP_LATENCY.
  - Zero-byteenable write: ACK at T1.
- Reset asserted mid-transaction:
  - Next cycle is IDLE, waitrequest=1, and no strobe is issued.
  - A pending RMW write is discarded.
- Avalon rule: the master holds the request until waitrequest=0. The bridge ignores request inputs outside IDLE.

Test Plan:
- Reset, then idle: avs_waitrequest=1, coe_pfc_cmd=0, avs_readdata=0.
- Full write, addr=4'b0110, data=32'h00110000, be=F, RESP_LATENCY=1:
  - At T1, cmd = {1,2'd1,2'd2,32'h00110000} for exactly one cycle.
  - waitrequest=0 at T2.
- Read, addr=4'b1101 (bank3 reg1), model resp=32'hDEADBEEF when cmd[35:32]=4'hD, RESP_LATENCY=1 and then 3:
  - readdata=32'hDEADBEEF.
  - ACK at T3 and T5 respectively.
- Partial write, resp=32'h11223344, data=32'hAABBCCDD, be=4'b0101:
  - One strobe with cmd[31:0]=32'h11BB33DD.
  - ACK at T3+RESP_LATENCY.
- NUM_BANKS=3, access to bank3:
  - Read returns 0.
  - Write acks at T2 with cmd[36] never high.
- Reset pulsed during RWAIT of a partial write:
  - No strobe.
  - waitrequest=1 after reset.
  - A subsequent full write to bank0 completes normally.
